// File: rtl/bip_debug_ctrl.sv
// bip_debug_ctrl: UART command sequencer that resets, steps or runs the BIP and dumps PC/Acc/cycle count; define BIP_DBG_BREAK_EN to allow an 'H' break out of RUN
module bip_debug_ctrl #(
    parameter logic [4:0] HALT_OPCODE = 5'b00000,
    parameter int         CYCLE_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done,
    input  logic [7:0]  d_in,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  d_out,
    input  logic [15:0] inPC,
    input  logic [15:0] inAcc,
    input  logic [4:0]  opcode,
    output logic        bip_en,
    output logic        reset_bip,
    output logic        halted
);
    typedef enum logic [2:0] {IDLE, RST, STEP, RUN, SNAP, TX, WAIT} state_t;

    state_t             state_q, state_d;
    logic [CYCLE_W-1:0] cnt_q, cnt_d;
    logic [5:0][7:0]    snap_q, snap_d;
    logic [2:0]         idx_q, idx_d;
    logic               halted_q, halted_d;
    logic               reset_bip_q, reset_bip_d;
    logic               at_halt, brk;

    assign at_halt = opcode == HALT_OPCODE;
`ifdef BIP_DBG_BREAK_EN
    assign brk = rx_done && d_in == 8'h48;
`else
    assign brk = 1'b0;
`endif

    // Next state, counter/snapshot updates and the combinational BIP enable
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        halted_d = halted_q;
        bip_en   = 1'b0;
        case (state_q)
            IDLE: if (rx_done)
                state_d = d_in == 8'h52 ? RST :
                          d_in == 8'h53 ? STEP :
                          d_in == 8'h47 ? RUN :
                          d_in == 8'h44 ? SNAP : IDLE;
            RST: begin
                cnt_d    = '0;
                halted_d = 1'b0;
                state_d  = IDLE;
            end
            STEP: begin
                bip_en  = !halted_q;
                state_d = SNAP;
            end
            RUN: begin
                bip_en   = !halted_q && !at_halt && !brk;
                halted_d = halted_q || at_halt;
                state_d  = bip_en ? RUN : SNAP;
            end
            SNAP: begin
                snap_d  = {inPC, inAcc, 16'(cnt_q)};
                idx_d   = '0;
                state_d = TX;
            end
            TX: state_d = WAIT;
            WAIT: if (tx_done) begin
                if (idx_q == 3'd5)
                    state_d = IDLE;
                else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = TX;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bip_en)
            cnt_d = cnt_q + CYCLE_W'(1);
        reset_bip_d = state_d == RST;
    end

    // State registers; reset_bip comes out of reset high so the BIP is held one cycle past reset release
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            snap_q      <= '0;
            idx_q       <= '0;
            halted_q    <= 1'b0;
            reset_bip_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            halted_q    <= halted_d;
            reset_bip_q <= reset_bip_d;
        end
    end

    assign tx_start  = state_q == TX;
    assign d_out     = snap_q[3'd5 - idx_q];
    assign reset_bip = reset_bip_q;
    assign halted    = halted_q;
endmodule
